// File: rtl/muldiv_pkg.sv
// ============================================================================
// muldiv_pkg : shared op codes, FSM states and sizing helpers for muldiv_seq
// Rev 1.0
// ============================================================================
`default_nettype none

package muldiv_pkg;

    localparam int C_DEFAULT_WIDTH = 32;

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } muldivOp_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } muldivState_e;

    // Iteration counter width: enough to count 0..width-1.
    function automatic int cntWidth(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/muldiv_seq_div_iter.sv
// ============================================================================
// div_iter : one combinational restoring radix-2 division step
// Rev 1.0
// ============================================================================
`default_nettype none

module div_iter #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH:0]   i_rem,
    input  logic [WIDTH-1:0] i_quo,
    input  logic [WIDTH-1:0] i_divisor,
    output logic [WIDTH:0]   o_rem,
    output logic [WIDTH-1:0] o_quo
);

    logic [WIDTH+1:0] w_shifted;
    logic [WIDTH+1:0] w_diff;
    logic             w_fits;

    // Dividend bits stream out of the quotient register's MSB into the remainder.
    assign w_shifted = {i_rem, i_quo[WIDTH-1]};
    assign w_diff    = w_shifted - {2'b00, i_divisor};
    assign w_fits    = ~w_diff[WIDTH+1];

    assign o_rem = w_fits ? w_diff[WIDTH:0] : w_shifted[WIDTH:0];
    assign o_quo = {i_quo[WIDTH-2:0], w_fits};

endmodule

`default_nettype wire

// File: rtl/muldiv_seq.sv
// ============================================================================
// muldiv_seq : multi-cycle MULT/MULTU/DIV/DIVU sequencer driving HILO writes
// Rev 1.0
// ============================================================================
`default_nettype none

module muldiv_seq
    import muldiv_pkg::*;
#(
    parameter int WIDTH = C_DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cancel,
    output logic             stall,
    output logic             hilo_we,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = cntWidth(WIDTH);

    muldivState_e     r_state;
    muldivState_e     w_nextState;
    muldivOp_e        r_op;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_quo;
    logic [WIDTH-1:0] r_divisor;
    logic [WIDTH:0]   r_rem;
    logic [CW-1:0]    r_cnt;
    logic             r_negQ;
    logic             r_negR;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;

    logic               w_accept;
    logic               w_signedDiv;
    logic               w_signedMul;
    logic               w_lastIter;
    logic [WIDTH-1:0]   w_absA;
    logic [WIDTH-1:0]   w_absB;
    logic [2*WIDTH-1:0] w_extA;
    logic [2*WIDTH-1:0] w_extB;
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH:0]     w_nextRem;
    logic [WIDTH-1:0]   w_nextQuo;
    logic [WIDTH-1:0]   w_quoFix;
    logic [WIDTH-1:0]   w_remFix;

    assign w_accept    = start & ~cancel;
    assign w_signedDiv = (muldivOp_e'(op) == OP_DIV);
    assign w_absA      = (w_signedDiv && a[WIDTH-1]) ? -a : a;
    assign w_absB      = (w_signedDiv && b[WIDTH-1]) ? -b : b;
    assign w_lastIter  = (r_cnt == CW'(WIDTH - 1));

    // Sign-extending to 2*WIDTH makes the low 2*WIDTH product bits correct for both flavours.
    assign w_signedMul = (r_op == OP_MULT);
    assign w_extA      = {{WIDTH{w_signedMul & r_a[WIDTH-1]}}, r_a};
    assign w_extB      = {{WIDTH{w_signedMul & r_b[WIDTH-1]}}, r_b};
    assign w_prod      = w_extA * w_extB;

    div_iter #(
        .WIDTH (WIDTH)
    ) u_divIter (
        .i_rem     (r_rem),
        .i_quo     (r_quo),
        .i_divisor (r_divisor),
        .o_rem     (w_nextRem),
        .o_quo     (w_nextQuo)
    );

    assign w_quoFix = r_negQ ? -w_nextQuo : w_nextQuo;
    assign w_remFix = r_negR ? -w_nextRem[WIDTH-1:0] : w_nextRem[WIDTH-1:0];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        stall       = 1'b0;
        hilo_we     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    stall       = 1'b1;
                    w_nextState = op[1] ? ST_DIV : ST_MUL;
                end
            end
            ST_MUL: begin
                stall       = 1'b1;
                w_nextState = ST_DONE;
            end
            ST_DIV: begin
                stall = 1'b1;
                if (w_lastIter) begin
                    w_nextState = ST_DONE;
                end
            end
            ST_DONE: begin
                hilo_we     = 1'b1;
                w_nextState = ST_IDLE;
            end
            default: w_nextState = ST_IDLE;
        endcase
        if (cancel) begin
            w_nextState = ST_IDLE;
            hilo_we     = 1'b0;
        end
        // Outputs must read zero while reset is held, even with start high.
        if (!rst) begin
            stall   = 1'b0;
            hilo_we = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_op      <= OP_MULT;
            r_a       <= '0;
            r_b       <= '0;
            r_quo     <= '0;
            r_divisor <= '0;
            r_rem     <= '0;
            r_cnt     <= '0;
            r_negQ    <= 1'b0;
            r_negR    <= 1'b0;
            r_hi      <= '0;
            r_lo      <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_op      <= muldivOp_e'(op);
                        r_a       <= a;
                        r_b       <= b;
                        r_rem     <= '0;
                        r_quo     <= w_absA;
                        r_divisor <= w_absB;
                        r_negQ    <= w_signedDiv & (a[WIDTH-1] ^ b[WIDTH-1]);
                        r_negR    <= w_signedDiv & a[WIDTH-1];
                        r_cnt     <= '0;
                    end
                end
                ST_MUL: begin
                    {r_hi, r_lo} <= w_prod;
                end
                ST_DIV: begin
                    r_rem <= w_nextRem;
                    r_quo <= w_nextQuo;
                    r_cnt <= r_cnt + CW'(1);
                    if (w_lastIter) begin
                        // Divide by zero reports the raw dividend and an all-ones quotient.
                        if (r_divisor == '0) begin
                            r_hi <= r_a;
                            r_lo <= '1;
                        end else begin
                            r_hi <= w_remFix;
                            r_lo <= w_quoFix;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign hi = r_hi;
    assign lo = r_lo;

endmodule

`default_nettype wire

// File: tb/tb_muldiv_seq.sv
// ============================================================================
// tb_muldiv_seq : randomized + directed self-checking bench for muldiv_seq
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_muldiv_seq;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cancel;
    logic         stall;
    logic         hilo_we;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    int nChecks = 0;
    int nErrors = 0;

    always #5 clk = ~clk;

    muldiv_seq #(
        .WIDTH (W)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .op      (op),
        .a       (a),
        .b       (b),
        .cancel  (cancel),
        .stall   (stall),
        .hilo_we (hilo_we),
        .hi      (hi),
        .lo      (lo)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nChecks++;
        if (got !== exp) begin
            nErrors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference {hi, lo} from plain integer arithmetic.
    function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        longint          sx;
        longint          sy;
        longint unsigned ux;
        longint unsigned uy;
        logic [63:0]     res;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        ux = {32'b0, x};
        uy = {32'b0, y};
        case (o)
            2'b00:   res = sx * sy;
            2'b01:   res = ux * uy;
            2'b10:   res = (y == 0) ? {x, 32'hFFFF_FFFF} : {32'(sx % sy), 32'(sx / sy)};
            default: res = (y == 0) ? {x, 32'hFFFF_FFFF} : {32'(ux % uy), 32'(ux / uy)};
        endcase
        return res;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        tick();
        start  = 1'b0;
        cancel = 1'b0;
        #1;
        check("idle_ctl", {62'b0, stall, hilo_we}, 64'd0);
    endtask

    task automatic runOp(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y, input string tag);
        int          lat;
        int          bad;
        logic [63:0] exp;
        lat = o[1] ? W + 1 : 2;
        bad = 0;
        exp = model(o, x, y);
        tick();
        start  = 1'b1;
        op     = o;
        a      = x;
        b      = y;
        cancel = 1'b0;
        #1;
        check({tag, "_accept"}, {62'b0, stall, hilo_we}, 64'd2);
        for (int c = 1; c < lat; c++) begin
            tick();
            #1;
            if (!(stall === 1'b1 && hilo_we === 1'b0)) bad++;
        end
        check({tag, "_busy"}, 64'(bad), 64'd0);
        tick();
        #1;
        check({tag, "_done"}, {62'b0, stall, hilo_we}, 64'd1);
        check({tag, "_hilo"}, {hi, lo}, exp);
    endtask

    initial begin
        logic [1:0]  ro;
        logic [31:0] rx;
        logic [31:0] ry;
        rst    = 1'b0;
        start  = 1'b0;
        cancel = 1'b0;
        op     = 2'b00;
        a      = '0;
        b      = '0;
        repeat (2) @(posedge clk);
        #2;
        check("reset_ctl", {62'b0, stall, hilo_we}, 64'd0);
        check("reset_hilo", {hi, lo}, 64'd0);
        tick();
        rst = 1'b1;

        runOp(2'b00, 32'hFFFF_FFFE, 32'd3, "mult_neg");
        idle();
        check("hilo_hold", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFA);
        runOp(2'b11, 32'd100, 32'd7, "divu");
        runOp(2'b10, -32'sd7, 32'd2, "div_neg");
        runOp(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
        runOp(2'b11, 32'h1234, 32'd0, "divu_by0");
        runOp(2'b10, 32'hFFFF_FF00, 32'd0, "div_by0");
        idle();

        // Cancel a DIV at cycle 10, then a MULTU must be accepted straight away.
        tick();
        start = 1'b1; op = 2'b10; a = 32'd1000; b = 32'd3;
        for (int c = 1; c < 10; c++) tick();
        tick();
        cancel = 1'b1;
        #1;
        check("cancel_c10_we", {63'b0, hilo_we}, 64'd0);
        tick();
        start  = 1'b0;
        cancel = 1'b0;
        #1;
        check("cancel_c11_ctl", {62'b0, stall, hilo_we}, 64'd0);
        runOp(2'b01, 32'd5, 32'd6, "multu_after_cancel");
        idle();

        // Cancel in DONE suppresses the write pulse in the same cycle.
        tick();
        start = 1'b1; op = 2'b00; a = 32'd7; b = 32'd9;
        tick();
        tick();
        cancel = 1'b1;
        #1;
        check("done_cancel_we", {63'b0, hilo_we}, 64'd0);
        idle();

        // Reset in the middle of a DIV.
        tick();
        start = 1'b1; op = 2'b10; a = 32'd12345; b = -32'sd17;
        for (int c = 1; c < 20; c++) tick();
        tick();
        rst = 1'b0;
        #1;
        check("midreset_ctl", {62'b0, stall, hilo_we}, 64'd0);
        check("midreset_hilo", {hi, lo}, 64'd0);
        tick();
        rst   = 1'b1;
        start = 1'b0;
        runOp(2'b11, 32'hDEAD_BEEF, 32'h1001, "divu_after_reset");

        for (int i = 0; i < 40; i++) begin
            ro = 2'($urandom_range(0, 3));
            rx = (($urandom_range(0, 7)) == 0) ? 32'h8000_0000 : $urandom;
            case ($urandom_range(0, 7))
                0:       ry = 32'd0;
                1:       ry = 32'($urandom_range(1, 15));
                2:       ry = 32'hFFFF_FFFF;
                default: ry = $urandom;
            endcase
            runOp(ro, rx, ry, "rand");
            if ($urandom_range(0, 1) == 1) idle();
        end
        idle();

        $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not reach its end, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire

// File: doc/muldiv_seq.md
# muldiv_seq

Multi-cycle sequencer for HI/LO-writing arithmetic (MULT, MULTU, DIV, DIVU) in the EX stage of the 5-stage MIPS pipeline.
- Accepts an operation from EX, holds the pipeline via `stall` while it iterates, then presents a 64-bit {hi, lo} result with a one-cycle `hilo_we` pulse.
- The pipeline controller already decodes the HILO write/read selects; this block owns the timing of when HILO is actually written.

## Interface
- `WIDTH`, 32: operand width; hi/lo are each WIDTH bits.
- `clk` in 1: clock; all state updates on the rising edge.
- `rst` in 1: reset. Single clock; `rst` is asynchronous and active-low.
- `start` in 1: EX holds a muldiv instruction; stays high for as long as the instruction sits in EX.
- `op` in 2: operation code: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- `a` in WIDTH: rs operand (dividend / multiplicand).
- `b` in WIDTH: rt operand (divisor / multiplier).
- `cancel` in 1: EX flush (branch/exception); aborts any operation.
- `stall` out 1: hold IF/ID/EX; combinational.
- `hilo_we` out 1: write {hi, lo} into HILO this cycle; combinational from state.
- `hi` out WIDTH: upper result (product high / remainder).
- `lo` out WIDTH: lower result (product low / quotient).

## Operation
FSM states: IDLE, MUL, DIV, DONE.

- **IDLE**
  - If `start` and not `cancel`: latch `a`, `b`, `op`.
  - For divides, also latch |a|, |b| and the sign flags (signed op only).
  - Next state: MUL for op 0x, DIV for op 1x.
- **MUL**
  - Register the full 2·WIDTH product: signed for MULT, unsigned for MULTU.
  - Next state: DONE.
- **DIV**
  - Restoring radix-2 divide, one quotient bit per cycle.
  - 5-bit iteration counter counts 0..WIDTH-1; after the WIDTH-th iteration, next state is DONE.
- **DONE**
  - `hi`/`lo` valid; `hilo_we` = ~`cancel`.
  - Next state: IDLE unconditionally, regardless of `start`, because the instruction leaves EX at this edge.
- **Signed correction** (DIV only, applied when entering DONE):
  - Quotient is negated if sign(a) ≠ sign(b).
  - Remainder takes the sign of `a`.
- **Overflow case**: -2^31 / -1 → lo = 0x8000_0000, hi = 0.
- **Divide by zero** (b == 0, both DIV and DIVU):
  - Full iteration count still runs.
  - Result is lo = all-ones, hi = `a` (raw operand); sign correction is suppressed.
- **`stall` equation**: (IDLE & `start` & ~`cancel`) | MUL | DIV. Deasserted in DONE.
- **`cancel`**: in any state, next state is IDLE and no `hilo_we` is produced. Result registers may hold partial values.
- **Reset values**: state IDLE, counter 0, hi = 0, lo = 0, `stall` = 0, `hilo_we` = 0.
- **Reset mid-operation**: immediate return to IDLE; no write.

## Timing
- Cycle 0 is the cycle `start` is seen in IDLE.
- MULT/MULTU:
  - `stall` high in cycles 0–1.
  - DONE in cycle 2 with `hilo_we` = 1.
  - Instruction leaves EX at the end of cycle 2.
- DIV/DIVU:
  - `stall` high in cycles 0–WIDTH (33 cycles at WIDTH = 32).
  - DONE in cycle WIDTH+1 (cycle 33).
- Back-to-back ops: the next instruction reaches EX at cycle DONE+1 in IDLE and is accepted that cycle. There is no bubble beyond the op's own latency.
- `cancel` is sampled every cycle. A `cancel` in DONE suppresses `hilo_we` combinationally in the same cycle.
- `hi`/`lo` are stable from DONE until the next acceptance.

## Structure
- Shared package `muldiv_pkg`:
  - op encodings (MULT/MULTU/DIV/DIVU);
  - state enum (IDLE, MUL, DIV, DONE);
  - `WIDTH`-derived counter width.
- Sub-module `div_iter`: one restoring-division step.
  - Inputs: partial remainder (WIDTH+1 bits), quotient shift register, divisor.
  - Outputs: next partial remainder and next quotient.
  - Purely combinational; registered in the parent.
- Multiplier is an inferred `*` registered in MUL. No separate module.

## Test plan
- MULT a=0xFFFF_FFFE (-2), b=3 → stall cycles 0–1; DONE cycle 2: hi=0xFFFF_FFFF, lo=0xFFFF_FFFA, hilo_we=1 for exactly one cycle.
- DIVU a=100, b=7 → stall for 33 cycles; cycle 33: lo=14, hi=2, hilo_we=1; stall=0.
- DIV a=-7, b=2 → lo=0xFFFF_FFFD (-3), hi=0xFFFF_FFFF (-1). DIV a=0x8000_0000, b=-1 → lo=0x8000_0000, hi=0.
- DIVU a=0x1234, b=0 → after 33 cycles lo=0xFFFF_FFFF, hi=0x1234.
- DIV started, cancel at cycle 10 → cycle 11 state IDLE, stall=0, no hilo_we pulse. A MULTU 5×6 issued next accepts immediately → lo=30, hi=0.
- rst pulled low at cycle 20 of a DIV → stall, hilo_we, hi, lo all 0 immediately. After release, a new DIVU completes with the full 33-cycle latency.
